fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with an IF/ID pipeline register.
// Two states: RUN fetches sequentially from the ROM window [0, PC_LIMIT).
// HALT parks the PC and feeds bubbles until a redirect back into the window.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_LIMIT = 16'd32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_target,
    input  logic        i_jump,
    input  logic [15:0] i_jump_target,
    output logic [15:0] o_pc_out,
    input  logic [15:0] i_instr_in,
    output logic [15:0] o_if_id_instr,
    output logic [15:0] o_if_id_pc_plus2,
    output logic        o_if_id_valid,
    output logic        o_halted,
    output logic [15:0] o_fetch_count
);

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_pc_plus2;
    logic        r_valid;
    logic        r_halted;
    logic [15:0] r_count;

    logic        w_redirect;
    logic [15:0] w_target;
    logic [15:0] w_pc_next;

    // Jump wins over branch; targets are halfword aligned by dropping bit 0.
    always_comb begin
        w_redirect = i_jump | i_branch_taken;
        w_target   = i_jump ? {i_jump_target[15:1], 1'b0}
                            : {i_branch_target[15:1], 1'b0};
        w_pc_next  = r_pc + 16'd2;
    end

    // Fetch FSM: PC, IF/ID register, halt flag and delivered-instruction count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= 16'h0000;
            r_pc_plus2 <= 16'h0000;
            r_valid    <= 1'b0;
            r_count    <= 16'h0000;
            r_state    <= (RESET_PC >= PC_LIMIT) ? S_HALT : S_RUN;
            r_halted   <= (RESET_PC >= PC_LIMIT);
        end else if (w_redirect) begin
            // Redirect overrides stall and HALT; the target decides the next state.
            r_pc       <= w_target;
            r_instr    <= 16'h0000;
            r_pc_plus2 <= 16'h0000;
            r_valid    <= 1'b0;
            r_state    <= (w_target >= PC_LIMIT) ? S_HALT : S_RUN;
            r_halted   <= (w_target >= PC_LIMIT);
        end else if (r_state == S_HALT) begin
            // Parked: PC holds, decode sees bubbles; stall/flush are irrelevant.
            r_instr    <= 16'h0000;
            r_pc_plus2 <= 16'h0000;
            r_valid    <= 1'b0;
        end else if (i_stall) begin
            // Hold everything, except a flush still kills the IF/ID entry.
            if (i_flush) begin
                r_instr    <= 16'h0000;
                r_pc_plus2 <= 16'h0000;
                r_valid    <= 1'b0;
            end
        end else begin
            r_pc <= w_pc_next;
            if (i_flush) begin
                r_instr    <= 16'h0000;
                r_pc_plus2 <= 16'h0000;
                r_valid    <= 1'b0;
            end else begin
                r_instr    <= i_instr_in;
                r_pc_plus2 <= w_pc_next;
                r_valid    <= 1'b1;
                if (r_count != 16'hFFFF)
                    r_count <= r_count + 16'd1;
            end
            // Leaving the ROM window: the current word is still delivered.
            if (w_pc_next >= PC_LIMIT) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
            end
        end
    end

    assign o_pc_out         = r_pc;
    assign o_if_id_instr    = r_instr;
    assign o_if_id_pc_plus2 = r_pc_plus2;
    assign o_if_id_valid    = r_valid;
    assign o_halted         = r_halted;
    assign o_fetch_count    = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized control traffic, checked
// against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam logic [15:0] LIMIT = 16'd32;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br, jmp;
    logic [15:0] bt, jt, instr;
    logic [15:0] pc, if_instr, if_pcp2, cnt;
    logic        if_valid, halted;
    logic [15:0] hi_pc, hi_instr, hi_pcp2, hi_cnt;
    logic        hi_valid, hi_halted;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] rom [32];

    // model state
    logic [15:0] m_pc, m_instr, m_pcp2, m_cnt;
    logic        m_valid, m_halt;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000), .PC_LIMIT(LIMIT)) dut (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
        .i_branch_taken(br), .i_branch_target(bt), .i_jump(jmp), .i_jump_target(jt),
        .o_pc_out(pc), .i_instr_in(instr), .o_if_id_instr(if_instr),
        .o_if_id_pc_plus2(if_pcp2), .o_if_id_valid(if_valid), .o_halted(halted),
        .o_fetch_count(cnt));

    // Second instance: reset PC outside the window must come up halted.
    fetch_unit #(.RESET_PC(16'h0040), .PC_LIMIT(LIMIT)) dut_hi (
        .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush(flush),
        .i_branch_taken(br), .i_branch_target(bt), .i_jump(jmp), .i_jump_target(jt),
        .o_pc_out(hi_pc), .i_instr_in(16'h1234), .o_if_id_instr(hi_instr),
        .o_if_id_pc_plus2(hi_pcp2), .o_if_id_valid(hi_valid), .o_halted(hi_halted),
        .o_fetch_count(hi_cnt));

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        if (a < 16'd64) return rom[a[5:1]];
        return a ^ 16'h5A5A;
    endfunction

    // ROM answers combinationally for whatever the DUT is fetching.
    always_comb instr = rom_word(pc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},    {16'h0, pc},       {16'h0, m_pc});
        chk({tag, ".instr"}, {16'h0, if_instr}, {16'h0, m_instr});
        chk({tag, ".pcp2"},  {16'h0, if_pcp2},  {16'h0, m_pcp2});
        chk({tag, ".valid"}, {31'h0, if_valid}, {31'h0, m_valid});
        chk({tag, ".halt"},  {31'h0, halted},   {31'h0, m_halt});
        chk({tag, ".cnt"},   {16'h0, cnt},      {16'h0, m_cnt});
    endtask

    function automatic void m_bubble();
        m_instr = 16'h0; m_pcp2 = 16'h0; m_valid = 1'b0;
    endfunction

    function automatic void m_reset();
        m_pc = 16'h0; m_cnt = 16'h0; m_halt = 1'b0;
        m_bubble();
    endfunction

    // One clock edge of the fetch stage, expressed in terms of its rules.
    function automatic void m_step(input logic s, f, b, j, input logic [15:0] btg, jtg);
        logic [15:0] w, nxt, tgt;
        w = rom_word(m_pc);
        if (j || b) begin
            tgt = (j ? jtg : btg) & 16'hFFFE;
            m_pc = tgt;
            m_halt = (tgt >= LIMIT);
            m_bubble();
        end else if (m_halt) begin
            m_bubble();
        end else if (s) begin
            if (f) m_bubble();
        end else begin
            nxt = m_pc + 16'd2;
            if (f) m_bubble();
            else begin
                m_instr = w; m_pcp2 = nxt; m_valid = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            m_pc = nxt;
            if (nxt >= LIMIT) m_halt = 1'b1;
        end
    endfunction

    task automatic step(input string tag, input logic s, f, b, j, input logic [15:0] btg, jtg);
        stall = s; flush = f; br = b; jmp = j; bt = btg; jt = jtg;
        @(posedge clk);
        m_step(s, f, b, j, btg, jtg);
        #1;
        chk_all(tag);
    endtask

    task automatic adv(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // Async reset: outputs must clear before any clock edge arrives.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        m_reset();
        chk_all({tag, ".async"});
        chk({tag, ".hi_halt"}, {31'h0, hi_halted}, 32'h1);
        chk({tag, ".hi_pc"},   {16'h0, hi_pc},     32'h0040);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_all({tag, ".held"});
    endtask

    initial begin
        rom[0] = 16'h8180; rom[1] = 16'h2CB2; rom[2] = 16'hDC67; rom[3] = 16'hDDD9;
        for (int k = 4; k < 32; k++) rom[k] = 16'(k * 16'h1111 + 16'h0F0F);
        reset = 1'b0; stall = 1'b0; flush = 1'b0; br = 1'b0; jmp = 1'b0;
        bt = 16'h0; jt = 16'h0;
        #2;
        do_reset("rst");

        // sequential fetch
        adv("seq", 4);
        chk("seq.cnt4", {16'h0, cnt}, 32'd4);
        chk("seq.pc8",  {16'h0, pc},  32'd8);
        chk("seq.last", {16'h0, if_instr}, 32'hDDD9);

        // stall at pc 4
        do_reset("rst2");
        adv("pre", 2);
        for (int k = 0; k < 3; k++) step("stall", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("stall.pc", {16'h0, pc}, 32'd4);
        step("rel", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("rel.pc", {16'h0, pc}, 32'd6);

        // flush variants
        step("flush", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        adv("adv", 1);
        step("flstall", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);

        // branch under stall, odd target
        step("brst", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
        chk("brst.pc", {16'h0, pc}, 32'd2);
        chk("brst.v",  {31'h0, if_valid}, 32'd0);

        // jump beats branch
        step("both", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 16'h000A);
        chk("both.pc", {16'h0, pc}, 32'h000A);

        // run to the window edge
        do_reset("rst3");
        adv("run", 16);
        chk("halt.pc",  {16'h0, pc},       32'd32);
        chk("halt.h",   {31'h0, halted},   32'd1);
        chk("halt.cnt", {16'h0, cnt},      32'd16);
        adv("halted", 2);
        chk("halted.v", {31'h0, if_valid}, 32'd0);
        step("hjmphi", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0050);
        step("hjmp0", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0000);
        chk("hjmp0.pc", {16'h0, pc},     32'd0);
        chk("hjmp0.h",  {31'h0, halted}, 32'd0);
        step("rjmphi", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0021, 16'h0);
        chk("rjmphi.h", {31'h0, halted}, 32'd1);

        // async reset mid-cycle at pc 12
        do_reset("rst4");
        adv("to12", 6);
        chk("to12.pc", {16'h0, pc}, 32'd12);
        #3;
        do_reset("rst41");

        // randomized control traffic
        for (int k = 0; k < 2000; k++) begin
            logic s, f, b, j;
            logic [15:0] btg, jtg;
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 6) == 0);
            b = ($urandom_range(0, 11) == 0);
            j = ($urandom_range(0, 19) == 0);
            btg = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 36));
            jtg = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 36));
            if ($urandom_range(0, 99) == 0) do_reset("rrst");
            else step("rnd", s, f, b, j, btg, jtg);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
